// File: rtl/counter_sequencer.sv
// Up/down counter driven by two debounced active-low buttons, with an auto-step
// mode (RUN_UP / RUN_DOWN / PAUSE) enabled by a static switch.

module CounterSequencerDebounce #(
  parameter logic [24:0] DEBOUNCE = 25'd2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  logic        r_armed;
  logic [24:0] r_cnt;
  logic        r_press;
  logic        w_levelOk;

  // Disarmed: qualify a released (high) button. Armed: qualify a press (low).
  assign w_levelOk = r_armed ? ~i_btn : i_btn;
  assign o_press   = r_press;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (!w_levelOk) begin
        r_cnt <= '0;
      end else if (r_cnt == DEBOUNCE) begin
        r_cnt   <= '0;
        r_armed <= ~r_armed;
        r_press <= r_armed;
      end else begin
        r_cnt <= r_cnt + 25'd1;
      end
    end
  end

endmodule

module counter_sequencer #(
  parameter int          BITS        = 4,
  parameter logic [24:0] DEBOUNCE    = 25'd2000000,
  parameter logic [24:0] AUTO_PERIOD = 25'd25000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic            auto_en,
  output logic [BITS-1:0] LEDS,
  output logic            running,
  output logic            dir
);

  typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN, PAUSE} state_t;

  localparam logic [24:0] TICK_LAST = AUTO_PERIOD - 25'd1;

  state_t          r_state, w_nextState;
  logic [BITS-1:0] r_count, w_nextCount;
  logic            r_dir, w_nextDir;
  logic [24:0]     r_tick, w_nextTick;
  logic            w_upReq, w_downReq;
  logic            w_upOnly, w_downOnly, w_both;

  CounterSequencerDebounce #(.DEBOUNCE(DEBOUNCE)) u_debUp (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_up),
    .o_press (w_upReq)
  );

  CounterSequencerDebounce #(.DEBOUNCE(DEBOUNCE)) u_debDown (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_down),
    .o_press (w_downReq)
  );

  assign w_upOnly   = w_upReq & ~w_downReq;
  assign w_downOnly = w_downReq & ~w_upReq;
  assign w_both     = w_upReq & w_downReq;

  assign LEDS    = ~r_count;
  assign running = (r_state == RUN_UP) || (r_state == RUN_DOWN);
  assign dir     = r_dir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_dir   <= 1'b1;
      r_tick  <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      r_dir   <= w_nextDir;
      r_tick  <= w_nextTick;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextDir   = r_dir;
    w_nextTick  = r_tick;

    unique case (r_state)
      IDLE: begin
        if (auto_en) begin
          w_nextState = r_dir ? RUN_UP : RUN_DOWN;
        end else if (w_upOnly) begin
          w_nextCount = r_count + BITS'(1);
          w_nextDir   = 1'b1;
        end else if (w_downOnly) begin
          w_nextCount = r_count - BITS'(1);
          w_nextDir   = 1'b0;
        end
      end
      RUN_UP, RUN_DOWN, PAUSE: begin
        // Dropping the auto switch outranks any button request.
        if (!auto_en) begin
          w_nextState = IDLE;
        end else if (w_both) begin
          if (r_state != PAUSE) w_nextState = PAUSE;
        end else if (w_upOnly) begin
          w_nextState = RUN_UP;
          w_nextDir   = 1'b1;
        end else if (w_downOnly) begin
          w_nextState = RUN_DOWN;
          w_nextDir   = 1'b0;
        end
      end
      default: w_nextState = IDLE;
    endcase

    // A state change restarts the period and suppresses any step due this edge.
    if (w_nextState != r_state) begin
      w_nextTick = '0;
    end else if (r_state == RUN_UP || r_state == RUN_DOWN) begin
      if (r_tick == TICK_LAST) begin
        w_nextTick  = '0;
        w_nextCount = r_dir ? (r_count + BITS'(1)) : (r_count - BITS'(1));
      end else begin
        w_nextTick = r_tick + 25'd1;
      end
    end
  end

endmodule
